// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS TX payload generator / error scheduler.
// lane_slice pulls one 8-bit lane out of a full payload word.
package lvds_tx_pkg;

  localparam int LANES  = 10;
  localparam int LANE_W = 8;
  localparam int INTV_W = 16;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINK,
    ST_RUN,
    ST_FINISH
  } state_t;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                    input logic [3:0]        idx);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == 4'(i)) r = word[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/lvds_tx_err_sched_if.sv
// Config/status and payload bundle between the register layer, the scheduler
// and the LVDS TX data input.
interface lvds_tx_err_sched_if #(
  parameter int LANES  = lvds_tx_pkg::LANES,
  parameter int LANE_W = lvds_tx_pkg::LANE_W,
  parameter int INTV_W = lvds_tx_pkg::INTV_W
);
  import lvds_tx_pkg::*;

  logic                      LVDS_INIT_DONE;
  logic                      CFG_START;
  logic                      CFG_STOP;
  logic [3:0]                CFG_CHN;
  logic [INTV_W-1:0]         CFG_INTERVAL;
  logic [INTV_W-1:0]         CFG_COUNT;
  logic [LANES*LANE_W-1:0]   TX_DATA;
  logic                      ERR_STROBE;
  logic [31:0]               ERR_TOTAL;
  logic                      BUSY;
  logic                      DONE;
  logic                      CFG_ERR;

  modport master (
    output LVDS_INIT_DONE, CFG_START, CFG_STOP, CFG_CHN, CFG_INTERVAL, CFG_COUNT,
    input  TX_DATA, ERR_STROBE, ERR_TOTAL, BUSY, DONE, CFG_ERR
  );

  modport slave (
    input  LVDS_INIT_DONE, CFG_START, CFG_STOP, CFG_CHN, CFG_INTERVAL, CFG_COUNT,
    output TX_DATA, ERR_STROBE, ERR_TOTAL, BUSY, DONE, CFG_ERR
  );

endinterface

// File: rtl/lvds_tx_pat_gen.sv
// Per-lane offset counting pattern with single-lane +1 corruption.
// TX_DATA and the error strobe are registered together so they stay aligned.
module lvds_tx_pat_gen #(
  parameter int LANES  = lvds_tx_pkg::LANES,
  parameter int LANE_W = lvds_tx_pkg::LANE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    insert_now,
  input  logic [3:0]              chn,
  output logic [LANES*LANE_W-1:0] tx_data,
  output logic                    err_strobe
);
  import lvds_tx_pkg::*;

  logic [LANE_W-1:0]       p;
  logic [LANES*LANE_W-1:0] word_next;

  always_comb begin
    word_next = '0;
    for (int i = 0; i < LANES; i++) begin
      word_next[i*LANE_W +: LANE_W] = p + LANE_W'(i) +
                                      ((insert_now && (chn == 4'(i))) ? LANE_W'(1) : LANE_W'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p          <= '0;
      tx_data    <= '0;
      err_strobe <= 1'b0;
    end else begin
      if (advance) p <= p + LANE_W'(1);
      tx_data    <= word_next;
      err_strobe <= insert_now;
    end
  end

endmodule

// File: rtl/lvds_tx_err_sched.sv
// Error-insertion campaign scheduler for the LVDS TX datapath: sequences
// start/stop, spacing and count of single-lane insertions on the payload.
module lvds_tx_err_sched #(
  parameter int LANES  = lvds_tx_pkg::LANES,
  parameter int LANE_W = lvds_tx_pkg::LANE_W,
  parameter int INTV_W = lvds_tx_pkg::INTV_W
) (
  input  logic                TX_CLK,
  input  logic                TX_RST,
  lvds_tx_err_sched_if.slave  bus
);
  import lvds_tx_pkg::*;

  state_t              state;
  logic [3:0]          chn;
  logic [INTV_W-1:0]   interval;
  logic [INTV_W-1:0]   count;
  logic [INTV_W-1:0]   dc;
  logic [INTV_W-1:0]   ins_cnt;
  logic                busy_q;
  logic                done_q;
  logic                cfg_err_q;
  logic [31:0]         err_total;
  logic                insert_now;
  logic                last_insert;
  logic                chn_ok;
  logic [LANES*LANE_W-1:0] tx_data;
  logic                err_strobe;

  assign chn_ok      = int'(bus.CFG_CHN) < LANES;
  assign insert_now  = (state == ST_RUN) && (dc == '0) && bus.LVDS_INIT_DONE;
  assign last_insert = (count != '0) && ((ins_cnt + INTV_W'(1)) == count);

  // Stop takes priority over start in IDLE; a stop coinciding with an
  // insertion in RUN still lets that insertion through and counts it.
  always_ff @(posedge TX_CLK or posedge TX_RST) begin
    if (TX_RST) begin
      state     <= ST_IDLE;
      chn       <= '0;
      interval  <= '0;
      count     <= '0;
      dc        <= '0;
      ins_cnt   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      busy_q    <= (state == ST_WAIT_LINK) || (state == ST_RUN);
      done_q    <= (state == ST_FINISH);
      cfg_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.CFG_START && !bus.CFG_STOP) begin
            if (chn_ok) begin
              chn      <= bus.CFG_CHN;
              interval <= (bus.CFG_INTERVAL == '0) ? INTV_W'(1) : bus.CFG_INTERVAL;
              count    <= bus.CFG_COUNT;
              ins_cnt  <= '0;
              state    <= ST_WAIT_LINK;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_LINK: begin
          if (bus.CFG_STOP) begin
            state <= ST_FINISH;
          end else if (bus.LVDS_INIT_DONE) begin
            dc    <= interval - INTV_W'(1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (insert_now) begin
            dc      <= interval - INTV_W'(1);
            ins_cnt <= ins_cnt + INTV_W'(1);
            if (bus.CFG_STOP || last_insert) state <= ST_FINISH;
          end else if (bus.CFG_STOP) begin
            state <= ST_FINISH;
          end else if (!bus.LVDS_INIT_DONE) begin
            state <= ST_WAIT_LINK;
          end else begin
            dc <= dc - INTV_W'(1);
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge TX_CLK or posedge TX_RST) begin
    if (TX_RST) begin
      err_total <= '0;
    end else if (err_strobe && (err_total != 32'hFFFF_FFFF)) begin
      err_total <= err_total + 32'd1;
    end
  end

  lvds_tx_pat_gen #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_pat_gen (
    .clk        (TX_CLK),
    .rst        (TX_RST),
    .advance    (bus.LVDS_INIT_DONE),
    .insert_now (insert_now),
    .chn        (chn),
    .tx_data    (tx_data),
    .err_strobe (err_strobe)
  );

  assign bus.TX_DATA    = tx_data;
  assign bus.ERR_STROBE = err_strobe;
  assign bus.ERR_TOTAL  = err_total;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.CFG_ERR    = cfg_err_q;

endmodule

// File: tb/tb_lvds_tx_err_sched.sv
// Directed bench for lvds_tx_err_sched: pattern, campaigns, rejects, link drop, reset.
module tb_lvds_tx_err_sched;
  import lvds_tx_pkg::*;

  logic TX_CLK = 1'b0;
  logic TX_RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] p_m, base_m;
  logic [7:0] got_l, exp_l;
  logic       exp_stb, exp_done, exp_busy;

  lvds_tx_err_sched_if intf ();

  lvds_tx_err_sched dut (
    .TX_CLK (TX_CLK),
    .TX_RST (TX_RST),
    .bus    (intf.slave)
  );

  always #5 TX_CLK = ~TX_CLK;

  // base_m is the p value the DUT used for the word currently on TX_DATA
  always @(posedge TX_CLK or posedge TX_RST) begin
    if (TX_RST) begin
      p_m    <= 8'd0;
      base_m <= 8'd0;
    end else begin
      base_m <= p_m;
      if (intf.LVDS_INIT_DONE) p_m <= p_m + 8'd1;
    end
  end

  task automatic tick();
    @(negedge TX_CLK);
  endtask

  task automatic test_reset();
    intf.LVDS_INIT_DONE = 1'b0;
    intf.CFG_START      = 1'b0;
    intf.CFG_STOP       = 1'b0;
    intf.CFG_CHN        = 4'd0;
    intf.CFG_INTERVAL   = 16'd0;
    intf.CFG_COUNT      = 16'd0;
    TX_RST = 1'b1;
    tick();
    tick();
    checks++; if (intf.TX_DATA !== 80'd0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", intf.TX_DATA); end
    checks++; if (intf.ERR_STROBE !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", intf.ERR_STROBE); end
    checks++; if (intf.ERR_TOTAL !== 32'd0) begin errors++; $display("FAIL reset_total got=%0d exp=0", intf.ERR_TOTAL); end
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", intf.BUSY); end
    checks++; if (intf.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", intf.DONE); end
    checks++; if (intf.CFG_ERR !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", intf.CFG_ERR); end
  endtask

  task automatic test_pattern();
    TX_RST = 1'b0;
    intf.LVDS_INIT_DONE = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int i = 0; i < LANES; i++) begin
        exp_l = 8'(k - 1 + i);
        got_l = lane_slice(intf.TX_DATA, 4'(i));
        checks++; if (got_l !== exp_l) begin errors++; $display("FAIL pattern k=%0d lane%0d got=%0d exp=%0d", k, i, got_l, exp_l); end
      end
      checks++; if (intf.ERR_STROBE !== 1'b0) begin errors++; $display("FAIL pattern_strobe k=%0d got=%b exp=0", k, intf.ERR_STROBE); end
      checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL pattern_busy k=%0d got=%b exp=0", k, intf.BUSY); end
    end
  endtask

  task automatic test_campaign();
    intf.CFG_CHN = 4'd3; intf.CFG_INTERVAL = 16'd4; intf.CFG_COUNT = 16'd2;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    intf.CFG_CHN = 4'd7; intf.CFG_INTERVAL = 16'd1; intf.CFG_COUNT = 16'd0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_stb  = (k == 5) || (k == 9);
      exp_done = (k == 10);
      exp_busy = (k <= 9);
      checks++; if (intf.ERR_STROBE !== exp_stb) begin errors++; $display("FAIL campaign_strobe k=%0d got=%b exp=%b", k, intf.ERR_STROBE, exp_stb); end
      checks++; if (intf.DONE !== exp_done) begin errors++; $display("FAIL campaign_done k=%0d got=%b exp=%b", k, intf.DONE, exp_done); end
      checks++; if (intf.BUSY !== exp_busy) begin errors++; $display("FAIL campaign_busy k=%0d got=%b exp=%b", k, intf.BUSY, exp_busy); end
      for (int i = 0; i < LANES; i++) begin
        exp_l = base_m + 8'(i) + ((exp_stb && i == 3) ? 8'd1 : 8'd0);
        got_l = lane_slice(intf.TX_DATA, 4'(i));
        checks++; if (got_l !== exp_l) begin errors++; $display("FAIL campaign_lane k=%0d lane%0d got=%0d exp=%0d", k, i, got_l, exp_l); end
      end
      intf.CFG_START = (k == 3);
    end
    checks++; if (intf.ERR_TOTAL !== 32'd2) begin errors++; $display("FAIL campaign_total got=%0d exp=2", intf.ERR_TOTAL); end
  endtask

  task automatic test_bad_chn();
    intf.CFG_CHN = 4'd12; intf.CFG_INTERVAL = 16'd4; intf.CFG_COUNT = 16'd1;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    checks++; if (intf.CFG_ERR !== 1'b1) begin errors++; $display("FAIL bad_chn_err got=%b exp=1", intf.CFG_ERR); end
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL bad_chn_busy got=%b exp=0", intf.BUSY); end
    tick();
    checks++; if (intf.CFG_ERR !== 1'b0) begin errors++; $display("FAIL bad_chn_err_pulse got=%b exp=0", intf.CFG_ERR); end
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL bad_chn_busy2 got=%b exp=0", intf.BUSY); end
    checks++; if (intf.ERR_STROBE !== 1'b0) begin errors++; $display("FAIL bad_chn_strobe got=%b exp=0", intf.ERR_STROBE); end
    intf.CFG_CHN = 4'd10;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    checks++; if (intf.CFG_ERR !== 1'b1) begin errors++; $display("FAIL chn10_err got=%b exp=1", intf.CFG_ERR); end
    tick();
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL chn10_busy got=%b exp=0", intf.BUSY); end
    intf.CFG_CHN = 4'd12;
    intf.CFG_START = 1'b1; intf.CFG_STOP = 1'b1;
    tick();
    intf.CFG_START = 1'b0; intf.CFG_STOP = 1'b0;
    checks++; if (intf.CFG_ERR !== 1'b0) begin errors++; $display("FAIL start_stop_err got=%b exp=0", intf.CFG_ERR); end
    tick();
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL start_stop_busy got=%b exp=0", intf.BUSY); end
    checks++; if (intf.ERR_TOTAL !== 32'd2) begin errors++; $display("FAIL bad_chn_total got=%0d exp=2", intf.ERR_TOTAL); end
  endtask

  task automatic test_continuous();
    intf.CFG_CHN = 4'd0; intf.CFG_INTERVAL = 16'd0; intf.CFG_COUNT = 16'd0;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_stb  = (k >= 2) && (k <= 7);
      exp_done = (k == 8);
      exp_busy = (k <= 7);
      checks++; if (intf.ERR_STROBE !== exp_stb) begin errors++; $display("FAIL cont_strobe k=%0d got=%b exp=%b", k, intf.ERR_STROBE, exp_stb); end
      checks++; if (intf.DONE !== exp_done) begin errors++; $display("FAIL cont_done k=%0d got=%b exp=%b", k, intf.DONE, exp_done); end
      checks++; if (intf.BUSY !== exp_busy) begin errors++; $display("FAIL cont_busy k=%0d got=%b exp=%b", k, intf.BUSY, exp_busy); end
      for (int i = 0; i < LANES; i++) begin
        exp_l = base_m + 8'(i) + ((exp_stb && i == 0) ? 8'd1 : 8'd0);
        got_l = lane_slice(intf.TX_DATA, 4'(i));
        checks++; if (got_l !== exp_l) begin errors++; $display("FAIL cont_lane k=%0d lane%0d got=%0d exp=%0d", k, i, got_l, exp_l); end
      end
      intf.CFG_STOP = (k == 6);
    end
    checks++; if (intf.ERR_TOTAL !== 32'd8) begin errors++; $display("FAIL cont_total got=%0d exp=8", intf.ERR_TOTAL); end
  endtask

  task automatic test_link_drop();
    intf.CFG_CHN = 4'd9; intf.CFG_INTERVAL = 16'd10; intf.CFG_COUNT = 16'd3;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_stb  = (k == 19) || (k == 29) || (k == 39);
      exp_done = (k == 40);
      exp_busy = (k <= 39);
      checks++; if (intf.ERR_STROBE !== exp_stb) begin errors++; $display("FAIL drop_strobe k=%0d got=%b exp=%b", k, intf.ERR_STROBE, exp_stb); end
      checks++; if (intf.DONE !== exp_done) begin errors++; $display("FAIL drop_done k=%0d got=%b exp=%b", k, intf.DONE, exp_done); end
      checks++; if (intf.BUSY !== exp_busy) begin errors++; $display("FAIL drop_busy k=%0d got=%b exp=%b", k, intf.BUSY, exp_busy); end
      for (int i = 0; i < LANES; i++) begin
        exp_l = base_m + 8'(i) + ((exp_stb && i == 9) ? 8'd1 : 8'd0);
        got_l = lane_slice(intf.TX_DATA, 4'(i));
        checks++; if (got_l !== exp_l) begin errors++; $display("FAIL drop_lane k=%0d lane%0d got=%0d exp=%0d", k, i, got_l, exp_l); end
      end
      if (k == 5) intf.LVDS_INIT_DONE = 1'b0;
      if (k == 8) intf.LVDS_INIT_DONE = 1'b1;
    end
    checks++; if (intf.ERR_TOTAL !== 32'd11) begin errors++; $display("FAIL drop_total got=%0d exp=11", intf.ERR_TOTAL); end
  endtask

  task automatic test_reset_mid();
    intf.CFG_CHN = 4'd1; intf.CFG_INTERVAL = 16'd2; intf.CFG_COUNT = 16'd0;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (intf.ERR_TOTAL !== 32'd12) begin errors++; $display("FAIL mid_total_pre got=%0d exp=12", intf.ERR_TOTAL); end
    checks++; if (intf.BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", intf.BUSY); end
    #2 TX_RST = 1'b1;
    #1;
    checks++; if (intf.TX_DATA !== 80'd0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", intf.TX_DATA); end
    checks++; if (intf.ERR_STROBE !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe got=%b exp=0", intf.ERR_STROBE); end
    checks++; if (intf.ERR_TOTAL !== 32'd0) begin errors++; $display("FAIL mid_rst_total got=%0d exp=0", intf.ERR_TOTAL); end
    checks++; if (intf.BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", intf.BUSY); end
    checks++; if (intf.DONE !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b exp=0", intf.DONE); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (intf.DONE !== 1'b0) begin errors++; $display("FAIL mid_rst_hold_done k=%0d got=%b exp=0", k, intf.DONE); end
    end
    TX_RST = 1'b0;
    intf.CFG_CHN = 4'd2; intf.CFG_INTERVAL = 16'd1; intf.CFG_COUNT = 16'd1;
    intf.CFG_START = 1'b1;
    tick();
    intf.CFG_START = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_stb  = (k == 2);
      exp_done = (k == 3);
      exp_busy = (k <= 2);
      checks++; if (intf.ERR_STROBE !== exp_stb) begin errors++; $display("FAIL post_rst_strobe k=%0d got=%b exp=%b", k, intf.ERR_STROBE, exp_stb); end
      checks++; if (intf.DONE !== exp_done) begin errors++; $display("FAIL post_rst_done k=%0d got=%b exp=%b", k, intf.DONE, exp_done); end
      checks++; if (intf.BUSY !== exp_busy) begin errors++; $display("FAIL post_rst_busy k=%0d got=%b exp=%b", k, intf.BUSY, exp_busy); end
      for (int i = 0; i < LANES; i++) begin
        exp_l = base_m + 8'(i) + ((exp_stb && i == 2) ? 8'd1 : 8'd0);
        got_l = lane_slice(intf.TX_DATA, 4'(i));
        checks++; if (got_l !== exp_l) begin errors++; $display("FAIL post_rst_lane k=%0d lane%0d got=%0d exp=%0d", k, i, got_l, exp_l); end
      end
    end
    checks++; if (intf.ERR_TOTAL !== 32'd1) begin errors++; $display("FAIL post_rst_total got=%0d exp=1", intf.ERR_TOTAL); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_campaign();
    test_bad_chn();
    test_continuous();
    test_link_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
